// File: rtl/piso_shift_reg_pkg.sv
// Shared encodings for the serial shift-register pair (PISO transmitter / SIPO receiver).
// Both ends must agree on the bit-order encoding carried on dir.
package piso_shift_reg_pkg;

  localparam int D_SIZE_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_reg_bit_counter.sv
// Mod-N up counter with synchronous clear and enable; tc_o flags count == N-1.
// The count never passes N-1: an increment at terminal count returns to 0.
module bit_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out transmitter: takes a word on a valid/ready handshake and shifts it
// out one bit per enabled cycle, MSB- or LSB-first, with back-to-back frames and no bubble.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [D_SIZE-1:0] din,
  input  logic              dir,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              en,
  output logic              out,
  output logic              out_valid,
  output logic              last
);

  if (D_SIZE < 2) begin : g_bad_size
    $error("piso_shift_reg: D_SIZE must be >= 2");
  end

  state_e            state_q, state_d;
  logic [D_SIZE-1:0] shreg_q, shreg_d;
  logic              dir_q, dir_d;
  logic              tc;
  logic              shifting, take, load;
  logic              cnt_clr, cnt_inc;

  assign shifting   = (state_q == ST_SHIFT);
  assign take       = shifting && en;
  assign last       = shifting && tc;
  assign out_valid  = shifting;
  // Ready on the final bit lets the next word replace it on the same edge.
  assign load_ready = !shifting || (last && en);
  assign load       = load_valid && load_ready;
  assign out        = shifting && ((dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[D_SIZE-1]);

  assign cnt_clr = load || (take && tc);
  assign cnt_inc = take && !tc;

  bit_counter #(
    .N (D_SIZE)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    if (load) begin
      state_d = ST_SHIFT;
      shreg_d = din;
      dir_d   = dir;
    end else if (take && tc) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (take) begin
      shreg_d = (dir_q == DIR_LSB_FIRST) ? {1'b0, shreg_q[D_SIZE-1:1]}
                                         : {shreg_q[D_SIZE-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (D_SIZE = 4): driver pushes hand-computed bit sequences,
// a negedge monitor pops and compares each consumed bit and rebuilds each received word.
module tb_piso_shift_reg;

  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [D-1:0] din;
  logic         dir;
  logic         load_valid;
  logic         load_ready;
  logic         en;
  logic         out;
  logic         out_valid;
  logic         last;

  piso_shift_reg #(.D_SIZE(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dir        (dir),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .en         (en),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
  } exp_bit_t;

  exp_bit_t     exp_q[$];
  logic [D:0]   frm_q[$];   // {dir, din} per accepted frame
  int           n_pass = 0;
  int           n_total = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // seq[D-1] is the first bit expected on the wire
  task automatic push_frame(input logic [D-1:0] w, input logic d, input logic [D-1:0] seq);
    exp_bit_t e;
    for (int i = D - 1; i >= 0; i--) begin
      e.b = seq[i];
      e.l = (i == 0);
      exp_q.push_back(e);
    end
    frm_q.push_back({d, w});
  endtask

  // Monitor / scoreboard, plus a receiver model that reassembles each frame
  logic [D-1:0] acc;
  initial begin
    exp_bit_t   e;
    logic [D:0] f;
    acc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        frm_q.delete();
        acc = '0;
      end else if (!out_valid) begin
        chk("idle_out", {7'd0, out}, 8'd0);
        chk("idle_last", {7'd0, last}, 8'd0);
        chk("idle_ready", {7'd0, load_ready}, 8'd1);
      end else if (exp_q.size() == 0 || frm_q.size() == 0) begin
        chk("unexpected_bit", {7'd0, out_valid}, 8'd0);
      end else begin
        e = exp_q[0];
        chk("last", {7'd0, last}, {7'd0, e.l});
        chk("load_ready", {7'd0, load_ready}, {7'd0, e.l && en});
        if (en) begin
          void'(exp_q.pop_front());
          chk("bit", {7'd0, out}, {7'd0, e.b});
          f = frm_q[0];
          acc = f[D] ? {out, acc[D-1:1]} : {acc[D-2:0], out};
          if (e.l) begin
            void'(frm_q.pop_front());
            chk("rx_word", {4'd0, acc}, {4'd0, f[D-1:0]});
            acc = '0;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; din = '0; dir = 1'b0; load_valid = 1'b0; en = 1'b0;

    // 1: async reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out", {7'd0, out}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_last", {7'd0, last}, 8'd0);
    chk("rst_ready", {7'd0, load_ready}, 8'd1);
    #18 rst_n = 1'b1;
    tick();

    // 2: MSB first
    en = 1'b1; din = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1011, 1'b0, 4'b1011);
    tick(); load_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("t2_valid_after", {7'd0, out_valid}, 8'd0);
    chk("t2_ready_after", {7'd0, load_ready}, 8'd1);
    tick();

    // 3: LSB first, dir/din toggled mid-frame
    din = 4'b1011; dir = 1'b1; load_valid = 1'b1;
    push_frame(4'b1011, 1'b1, 4'b1101);
    tick(); load_valid = 1'b0;
    tick(); dir = 1'b0; din = 4'b0000;
    repeat (3) tick();
    tick();

    // 4: stall after 2nd bit
    din = 4'b0110; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b0110, 1'b0, 4'b0110);
    tick(); load_valid = 1'b0;
    tick();
    tick(); en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out", {7'd0, out}, 8'd1);
      chk("stall_last", {7'd0, last}, 8'd0);
      chk("stall_ready", {7'd0, load_ready}, 8'd0);
    end
    tick(); en = 1'b1;
    repeat (2) tick();
    tick();

    // 5: back-to-back frames, load_valid held
    din = 4'b1100; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1100, 1'b0, 4'b1100);
    push_frame(4'b0011, 1'b0, 4'b0011);
    tick(); din = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_valid", {7'd0, out_valid}, 8'd1);
      if (i == 3) begin
        @(posedge clk);
        #1 load_valid = 1'b0;
      end
    end
    tick();
    tick();

    // 6: reset mid-frame, then clean frame
    din = 4'b1010; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b1010, 1'b0, 4'b1010);
    tick(); load_valid = 1'b0;
    tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out", {7'd0, out}, 8'd0);
    chk("abort_valid", {7'd0, out_valid}, 8'd0);
    chk("abort_last", {7'd0, last}, 8'd0);
    chk("abort_ready", {7'd0, load_ready}, 8'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    din = 4'b0101; dir = 1'b0; load_valid = 1'b1;
    push_frame(4'b0101, 1'b0, 4'b0101);
    tick(); load_valid = 1'b0;
    repeat (4) tick();
    tick();

    chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
    chk("frm_q_drained", 8'(frm_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
